// File: rtl/tl_rx_fc_pkg.sv
// Shared definitions for the TL RX flow-control overflow tracker:
// FC type codes, scale codes and the scaled-credit helper functions.
package tl_rx_fc_pkg;

    localparam int NUM_FC_TYPES = 3;
    localparam int HDR_W        = 12;
    localparam int DATA_W       = 16;
    localparam int DW_W         = 10;

    typedef enum logic [1:0] {
        FC_P    = 2'd0,
        FC_NP   = 2'd1,
        FC_CPL  = 2'd2,
        FC_RSVD = 2'd3
    } fc_type_e;

    typedef enum logic [1:0] {
        SCALE_LEGACY = 2'b00,
        SCALE_X1     = 2'b01,
        SCALE_X4     = 2'b10,
        SCALE_X16    = 2'b11
    } fc_scale_e;

    // Effective header credit field width for a scale code.
    function automatic int fc_hdr_width(input logic [1:0] scale);
        case (scale)
            SCALE_X4:  return 10;
            SCALE_X16: return 12;
            default:   return 8;
        endcase
    endfunction

    // Effective data credit field width for a scale code.
    function automatic int fc_data_width(input logic [1:0] scale);
        case (scale)
            SCALE_X4:  return 14;
            SCALE_X16: return 16;
            default:   return 12;
        endcase
    endfunction

    // All-ones mask of the given field width (width <= DATA_W).
    function automatic logic [DATA_W-1:0] fc_width_mask(input int width);
        return DATA_W'((32'd1 << width) - 32'd1);
    endfunction

    // Data credits consumed by a TLP: ceil(len / unit), unit = 4/16/64 DW by scale.
    function automatic logic [DATA_W-1:0] fc_data_creds(input logic [DW_W-1:0] len_dw,
                                                        input logic            has_data,
                                                        input logic [1:0]      scale);
        logic [DW_W:0]       w_sum;
        logic [DATA_W-1:0]   w_creds;
        case (scale)
            SCALE_X4: begin
                w_sum   = {1'b0, len_dw} + 11'd15;
                w_creds = DATA_W'(w_sum >> 4);
            end
            SCALE_X16: begin
                w_sum   = {1'b0, len_dw} + 11'd63;
                w_creds = DATA_W'(w_sum >> 6);
            end
            default: begin
                w_sum   = {1'b0, len_dw} + 11'd3;
                w_creds = DATA_W'(w_sum >> 2);
            end
        endcase
        return has_data ? w_creds : {DATA_W{1'b0}};
    endfunction

endpackage

// File: rtl/tl_rx_fc_overflow_tracker_credit_calc.sv
// Combinational data-credit requirement for one request under one data scale.
module tl_rx_fc_credit_calc
    import tl_rx_fc_pkg::*;
(
    input  logic              i_has_data,
    input  logic [DW_W-1:0]   i_len_dw,
    input  logic [1:0]        i_scale,
    output logic [DATA_W-1:0] o_need_data
);

    assign o_need_data = fc_data_creds(i_len_dw, i_has_data, i_scale);

endmodule

// File: rtl/tl_rx_fc_overflow_tracker.sv
// Receiver-overflow checker for the TL RX write path. Two-stage pipeline:
// S1 captures the request, S2 checks it against the DLL's CREDITS_ALLOCATED,
// updates the per-type CREDITS_RECEIVED counters and reports the result.
module tl_rx_fc_overflow_tracker
    import tl_rx_fc_pkg::*;
(
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_link_down,
    input  logic [2*NUM_FC_TYPES-1:0]      i_hdr_scale,
    input  logic [2*NUM_FC_TYPES-1:0]      i_data_scale,
    input  logic [NUM_FC_TYPES-1:0]        i_hdr_inf,
    input  logic [NUM_FC_TYPES-1:0]        i_data_inf,
    input  logic [HDR_W*NUM_FC_TYPES-1:0]  i_dll_hdr,
    input  logic [DATA_W*NUM_FC_TYPES-1:0] i_dll_data,
    input  logic                           i_chk_valid,
    input  logic [1:0]                     i_chk_type,
    input  logic                           i_chk_has_data,
    input  logic [DW_W-1:0]                i_chk_len_dw,
    input  logic                           i_chk_en,
    output logic                           o_err_valid,
    output logic                           o_err_overflow,
    output logic [1:0]                     o_err_type,
    output logic [NUM_FC_TYPES-1:0]        o_ovf_status,
    input  logic [NUM_FC_TYPES-1:0]        i_ovf_clr
);

    logic                    r_s1_valid;
    logic [1:0]              r_s1_type;
    logic                    r_s1_has_data;
    logic [DW_W-1:0]         r_s1_len_dw;
    logic                    w_req_ok;
    logic [NUM_FC_TYPES-1:0] w_hit;
    logic [NUM_FC_TYPES-1:0] w_reject;
    logic                    r_err_valid;
    logic                    r_err_overflow;
    logic [1:0]              r_err_type;
    logic [NUM_FC_TYPES-1:0] r_ovf_status;

    // Reserved type codes never enter the pipeline.
    assign w_req_ok = i_chk_valid && (i_chk_type < 2'(NUM_FC_TYPES));

    // S1: capture the request; link_down flushes anything in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_valid    <= 1'b0;
            r_s1_type     <= 2'd0;
            r_s1_has_data <= 1'b0;
            r_s1_len_dw   <= {DW_W{1'b0}};
        end else if (i_link_down) begin
            r_s1_valid    <= 1'b0;
            r_s1_type     <= 2'd0;
            r_s1_has_data <= 1'b0;
            r_s1_len_dw   <= {DW_W{1'b0}};
        end else begin
            r_s1_valid    <= w_req_ok;
            r_s1_type     <= i_chk_type;
            r_s1_has_data <= i_chk_has_data;
            r_s1_len_dw   <= i_chk_len_dw;
        end
    end

    // S2 per FC type: scaled-window compare and CREDITS_RECEIVED counters.
    for (genvar t = 0; t < NUM_FC_TYPES; t++) begin : g_fc
        logic [1:0]        w_hdr_scale;
        logic [1:0]        w_data_scale;
        logic [HDR_W-1:0]  w_hdr_mask;
        logic [HDR_W-1:0]  w_hdr_half;
        logic [HDR_W-1:0]  w_hdr_sum;
        logic [HDR_W-1:0]  w_hdr_left;
        logic [DATA_W-1:0] w_data_mask;
        logic [DATA_W-1:0] w_data_half;
        logic [DATA_W-1:0] w_need_data;
        logic [DATA_W-1:0] w_data_sum;
        logic [DATA_W-1:0] w_data_left;
        logic              w_hdr_ovf;
        logic              w_data_ovf;
        logic [HDR_W-1:0]  r_rcv_hdr;
        logic [DATA_W-1:0] r_rcv_data;

        assign w_hdr_scale  = i_hdr_scale[2*t +: 2];
        assign w_data_scale = i_data_scale[2*t +: 2];

        // Scale is applied in S2 so a scale change only affects later TLPs.
        tl_rx_fc_credit_calc u_credit_calc (
            .i_has_data  (r_s1_has_data),
            .i_len_dw    (r_s1_len_dw),
            .i_scale     (w_data_scale),
            .o_need_data (w_need_data)
        );

        // Window test: (allocated - (received + need)) mod 2^W in upper half = overflow.
        assign w_hdr_mask  = HDR_W'(fc_width_mask(fc_hdr_width(w_hdr_scale)));
        assign w_hdr_half  = (w_hdr_mask >> 1) + HDR_W'(1'b1);
        assign w_hdr_sum   = (r_rcv_hdr + HDR_W'(1'b1)) & w_hdr_mask;
        assign w_hdr_left  = (i_dll_hdr[HDR_W*t +: HDR_W] - w_hdr_sum) & w_hdr_mask;
        assign w_hdr_ovf   = !i_hdr_inf[t] && (w_hdr_left >= w_hdr_half);

        assign w_data_mask = fc_width_mask(fc_data_width(w_data_scale));
        assign w_data_half = (w_data_mask >> 1) + DATA_W'(1'b1);
        assign w_data_sum  = (r_rcv_data + w_need_data) & w_data_mask;
        assign w_data_left = (i_dll_data[DATA_W*t +: DATA_W] - w_data_sum) & w_data_mask;
        assign w_data_ovf  = !i_data_inf[t] && (w_data_left >= w_data_half);

        assign w_hit[t]    = r_s1_valid && (r_s1_type == 2'(t));
        assign w_reject[t] = i_chk_en && (w_hdr_ovf || w_data_ovf);

        // Counters advance only for accepted TLPs (infinite types still count).
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_rcv_hdr  <= {HDR_W{1'b0}};
                r_rcv_data <= {DATA_W{1'b0}};
            end else if (i_link_down) begin
                r_rcv_hdr  <= {HDR_W{1'b0}};
                r_rcv_data <= {DATA_W{1'b0}};
            end else if (w_hit[t] && !w_reject[t]) begin
                r_rcv_hdr  <= w_hdr_sum;
                r_rcv_data <= w_data_sum;
            end else begin
                r_rcv_hdr  <= r_rcv_hdr;
                r_rcv_data <= r_rcv_data;
            end
        end
    end

    // Result strobe and sticky status; a new overflow beats a same-cycle clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err_valid    <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_type     <= 2'd0;
            r_ovf_status   <= {NUM_FC_TYPES{1'b0}};
        end else if (i_link_down) begin
            r_err_valid    <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_type     <= 2'd0;
            r_ovf_status   <= {NUM_FC_TYPES{1'b0}};
        end else begin
            r_err_valid    <= r_s1_valid;
            r_err_overflow <= |(w_hit & w_reject);
            r_err_type     <= r_s1_valid ? r_s1_type : 2'd0;
            r_ovf_status   <= (r_ovf_status & ~i_ovf_clr) | (w_hit & w_reject);
        end
    end

    assign o_err_valid    = r_err_valid;
    assign o_err_overflow = r_err_overflow;
    assign o_err_type     = r_err_type;
    assign o_ovf_status   = r_ovf_status;

endmodule
